// File: rtl/zorro_arbiter.sv
// zorro_arbiter: Zorro II bus arbiter; forwards slot/coprocessor requests to the 68000 and hands
// its grant to one winner. Define ROUND_ROBIN_EN for rotating slot priority (default: fixed).

module zorro_slot_gnt (
    input  logic C7M,
    input  logic RESETn,
    input  logic sel,
    output logic gnt_n
);
    always_ff @(posedge C7M) begin
        if (!RESETn) gnt_n <= 1'b1;
        else         gnt_n <= ~sel;
    end
endmodule

module zorro_arbiter #(
    parameter int SLOTS         = 5,
    parameter int GRANT_TIMEOUT = 32
) (
    input  logic                       C7M,
    input  logic                       RESETn,
    input  logic [SLOTS:1]             BR,
    input  logic                       CBRn,
    input  logic                       BGn,
    input  logic                       OWNn,
    output logic                       BRn,
    output logic [SLOTS:1]             BG,
    output logic                       CBGn,
    output logic                       GTOn,
    output logic [$clog2(SLOTS+2)-1:0] OWNER
);
    localparam int OW = $clog2(SLOTS + 2);
    localparam int CW = $clog2(GRANT_TIMEOUT);
    localparam logic [OW-1:0] COP  = OW'(SLOTS + 1);
    localparam logic [CW-1:0] CMAX = CW'(GRANT_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, GRANT, OWNED} state_t;

    state_t           state, state_nxt;
    logic             bgold_n, gedge, tmo, tmo_q;
    logic [CW-1:0]    cnt;
    logic [OW-1:0]    win, pick;
    logic [SLOTS+1:0] reqv;
    logic [SLOTS:1]   slot_sel;
`ifdef ROUND_ROBIN_EN
    logic [OW-1:0]    ptr;
`endif

    // Active-high request vector indexed by owner code; bit 0 (CPU) never requests.
    always_comb begin
        reqv          = '0;
        reqv[SLOTS:1] = ~BR;
        reqv[SLOTS+1] = ~CBRn;
    end

    assign gedge = ~BGn & bgold_n;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
`ifdef ROUND_ROBIN_EN
        for (int k = SLOTS; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx > SLOTS) idx = idx - SLOTS;
            if (reqv[idx[OW-1:0]]) pick = idx[OW-1:0];
        end
`else
        for (int k = SLOTS; k >= 1; k--) begin
            idx = k;
            if (reqv[idx[OW-1:0]]) pick = idx[OW-1:0];
        end
`endif
        if (!CBRn) pick = COP;
    end

    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        case (state)
            IDLE:  if (|reqv) state_nxt = REQ;
            REQ:   if (gedge) state_nxt = (pick != '0) ? GRANT : IDLE;
            GRANT: begin
                if (!OWNn)            state_nxt = OWNED;
                else if (!reqv[win])  state_nxt = IDLE;
                else if (cnt == CMAX) begin
                    state_nxt = IDLE;
                    tmo       = 1'b1;
                end
            end
            OWNED: if (OWNn) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge C7M) begin
        if (!RESETn) begin
            state   <= IDLE;
            bgold_n <= 1'b1;
            tmo_q   <= 1'b0;
            cnt     <= '0;
            win     <= '0;
            BRn     <= 1'b1;
            CBGn    <= 1'b1;
            GTOn    <= 1'b1;
            OWNER   <= '0;
`ifdef ROUND_ROBIN_EN
            ptr     <= OW'(SLOTS);
`endif
        end else begin
            state   <= state_nxt;
            bgold_n <= BGn;
            tmo_q   <= tmo;
            if (state == REQ && state_nxt == GRANT) begin
                win <= pick;
                cnt <= '0;
`ifdef ROUND_ROBIN_EN
                if (pick != COP) ptr <= pick;
`endif
            end else if (state == GRANT && cnt != CMAX) begin
                cnt <= cnt + 1'b1;
            end
            // Outputs trail the state by one edge so every strobe is a clean register.
            BRn   <= ~(state == REQ);
            CBGn  <= ~(state == GRANT && win == COP);
            GTOn  <= ~tmo_q;
            OWNER <= (state == GRANT || state == OWNED) ? win : '0;
        end
    end

    for (genvar g = 1; g <= SLOTS; g++) begin : g_slot
        assign slot_sel[g] = (state == GRANT) && (win == OW'(g));
        zorro_slot_gnt u_gnt (
            .C7M    (C7M),
            .RESETn (RESETn),
            .sel    (slot_sel[g]),
            .gnt_n  (BG[g])
        );
    end
endmodule

// File: tb/tb_zorro_arbiter.sv
// tb_zorro_arbiter: directed plus randomized arbitration rounds checked against a
// transaction-level priority/timing model.

module tb_zorro_arbiter;
    localparam int SLOTS = 5;
    localparam int GT    = 32;
    localparam int OW    = $clog2(SLOTS + 2);

    logic             C7M = 1'b0;
    logic             RESETn;
    logic [SLOTS:1]   BR;
    logic             CBRn, BGn, OWNn;
    logic             BRn, CBGn, GTOn;
    logic [SLOTS:1]   BG;
    logic [OW-1:0]    OWNER;

    int n_chk = 0;
    int n_err = 0;
`ifdef ROUND_ROBIN_EN
    int rr_ptr = SLOTS;
`endif

    always #5 C7M = ~C7M;

    zorro_arbiter #(.SLOTS(SLOTS), .GRANT_TIMEOUT(GT)) dut (
        .C7M    (C7M),
        .RESETn (RESETn),
        .BR     (BR),
        .CBRn   (CBRn),
        .BGn    (BGn),
        .OWNn   (OWNn),
        .BRn    (BRn),
        .BG     (BG),
        .CBGn   (CBGn),
        .GTOn   (GTOn),
        .OWNER  (OWNER)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge C7M);
        #1;
    endtask

    // Expected winner from the priority rules; 0 means nobody requesting.
    function automatic int ref_winner(input bit cop, input bit [SLOTS:1] slots);
        if (cop) return SLOTS + 1;
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= SLOTS; k++) begin
            int s;
            s = (rr_ptr + k - 1) % SLOTS + 1;
            if (slots[s]) return s;
        end
`else
        for (int s = 1; s <= SLOTS; s++) if (slots[s]) return s;
`endif
        return 0;
    endfunction

    function automatic void note_grant(input int w);
`ifdef ROUND_ROBIN_EN
        if (w >= 1 && w <= SLOTS) rr_ptr = w;
`else
        if (w < 0) $display("note: negative winner %0d", w);
`endif
    endfunction

    task automatic chk_out(input string tag, input int w, input int own);
        logic [SLOTS:1] gv;
        gv = '1;
        if (w >= 1 && w <= SLOTS) gv[w] = 1'b0;
        chk({tag, "_bg"}, 32'(BG), 32'(gv));
        chk({tag, "_cbgn"}, 32'(CBGn), (w == SLOTS + 1) ? 0 : 1);
        chk({tag, "_owner"}, 32'(OWNER), own);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_brn"}, 32'(BRn), 1);
        chk({tag, "_gton"}, 32'(GTOn), 1);
        chk_out(tag, 0, 0);
    endtask

    // From IDLE: raise requests, let the 68000 grant, stop one edge after the grant appears.
    task automatic start_grant(input bit cop, input bit [SLOTS:1] slots, input int bgd, output int w);
        w = ref_winner(cop, slots);
        CBRn = ~cop;
        BR   = ~slots;
        tick(); chk("brn_idle", 32'(BRn), 1);
        tick(); chk("brn_req", 32'(BRn), 0);
        repeat (bgd) tick();
        BGn = 1'b0;
        tick(); chk_out("pre_gnt", 0, 0);
        tick(); BGn = 1'b1;
        chk_out("gnt", w, w);
        chk("gnt_gton", 32'(GTOn), 1);
        note_grant(w);
    endtask

    // Pending requests, then a grant edge with nobody left: no grant, back to IDLE.
    task automatic cleanup();
        BR = '1; CBRn = 1'b1;
        tick();
        BGn = 1'b0;
        tick();
        BGn = 1'b1;
        tick();
        chk("noreq_brn", 32'(BRn), 1);
        chk_out("noreq", 0, 0);
        tick();
    endtask

    // Already OWNED (grant just withdrawn); hold, release the bus with requests still pending.
    task automatic own_end(input int w, input int hold);
        repeat (hold) begin
            tick();
            chk_out("owned", 0, w);
            chk("owned_brn", 32'(BRn), 1);
        end
        OWNn = 1'b1;
        tick(); chk_out("rel_p", 0, w);
        tick(); chk_out("rel_p1", 0, 0); chk("rel_p1_brn", 32'(BRn), 1);
        tick(); chk("rel_p2_brn", 32'(BRn), 0);
        cleanup();
    endtask

    // mode 0: take bus after d; 1: never take (timeout); 2: take on terminal count; 3: drop request after d
    task automatic do_round(input bit cop, input bit [SLOTS:1] slots, input int bgd, input int mode,
                            input int d, input int hold);
        int w;
        start_grant(cop, slots, bgd, w);
        case (mode)
            0: begin
                repeat (d) begin tick(); chk_out("gnt_hold", w, w); end
                OWNn = 1'b0;
                tick(); chk_out("own_n", w, w);
                tick(); chk_out("own_n1", 0, w);
                own_end(w, hold);
            end
            1: begin
                for (int t = 1; t <= GT - 1; t++) begin
                    tick();
                    chk_out("to_hold", w, w);
                    chk("to_hold_gton", 32'(GTOn), 1);
                end
                BR = '1; CBRn = 1'b1;
                tick(); chk_out("to_drop", 0, 0); chk("to_pulse", 32'(GTOn), 0);
                chk("to_brn", 32'(BRn), 1);
                tick(); chk("to_pulse_end", 32'(GTOn), 1);
            end
            2: begin
                repeat (GT - 2) tick();
                chk_out("tc_hold", w, w);
                OWNn = 1'b0;
                tick(); chk_out("tc_edge", w, w); chk("tc_gton0", 32'(GTOn), 1);
                tick(); chk_out("tc_owned", 0, w); chk("tc_gton1", 32'(GTOn), 1);
                tick(); chk("tc_gton2", 32'(GTOn), 1);
                own_end(w, hold);
            end
            default: begin
                repeat (d) begin tick(); chk_out("rq_hold", w, w); end
                BR = '1; CBRn = 1'b1;
                tick(); chk_out("rq_edge", w, w);
                tick(); chk_out("rq_drop", 0, 0); chk("rq_gton", 32'(GTOn), 1);
                tick(); chk("rq_gton1", 32'(GTOn), 1);
            end
        endcase
    endtask

    initial begin
        int w;
        RESETn = 1'b0; BR = '1; CBRn = 1'b1; BGn = 1'b1; OWNn = 1'b1;
        repeat (2) tick();
        chk_reset_state("reset");
        RESETn = 1'b1;
        tick();

        // Two slots held over three rounds: fixed 1,1,1 / rotating 1,4,1.
        repeat (3) do_round(1'b0, 5'b01001, 0, 0, 1, 2);
        // Slot 3 with a late grant, owned for 10 cycles.
        do_round(1'b0, 5'b00100, 2, 0, 3, 10);
        // Coprocessor beats slots.
        do_round(1'b1, 5'b01001, 1, 0, 2, 2);
        // Grant never taken up, then taken exactly on the terminal count.
        do_round(1'b0, 5'b00010, 0, 1, 0, 0);
        do_round(1'b0, 5'b00010, 0, 2, 0, 2);

        // Request withdrawn while waiting for the 68000.
        BR = 5'b01111;
        tick(); tick(); chk("br5_brn", 32'(BRn), 0);
        cleanup();

        // Reset while a grant is still visible in OWNED.
        start_grant(1'b0, 5'b00010, 1, w);
        OWNn = 1'b0;
        tick();
        chk_out("pre_reset", 2, 2);
        RESETn = 1'b0;
        tick();
        chk_reset_state("mid_reset");
        RESETn = 1'b1; BR = '1; OWNn = 1'b1;
`ifdef ROUND_ROBIN_EN
        rr_ptr = SLOTS;
`endif
        tick(); tick();

        for (int i = 0; i < 40; i++) begin
            bit [SLOTS:1] s;
            bit c;
            s = SLOTS'($urandom_range(0, (1 << SLOTS) - 1));
            c = ($urandom_range(0, 3) == 0);
            if (s == '0 && !c) s[SLOTS] = 1'b1;
            do_round(c, s, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, GT - 3), $urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/zorro_arbiter.md
# zorro_arbiter

Parametrised Zorro II bus-mastering arbiter for the Amiga 2000 mainboard replacement logic; successor to the fixed five-slot Buster arbitration path. Collects active-low bus requests from `SLOTS` expansion slots plus the coprocessor slot and forwards a single request to the 68000. It hands the 68000's grant to exactly one winner, tracks ownership until the bus is released, and withdraws grants that are never taken up. The priority scheme is compile-time selectable.

## Interface
- `SLOTS`, 5, number of Zorro slot request/grant pairs (1..15)
- `GRANT_TIMEOUT`, 32, C7M cycles a granted master has to assert OWNn before the grant is withdrawn (≥2)
- `C7M` in 1, 7.09 MHz system clock; all logic on rising edge
- `RESETn` in 1, reset, synchronous, active-low
- `BR` in [SLOTS:1], slot bus requests, active-low
- `CBRn` in 1, coprocessor bus request, active-low
- `BGn` in 1, 68000 bus grant, active-low
- `OWNn` in 1, a bus master has taken the bus (BGACK/OWN), active-low
- `BRn` out 1, bus request to the 68000, active-low, registered
- `BG` out [SLOTS:1], slot bus grants, active-low, registered
- `CBGn` out 1, coprocessor bus grant, active-low, registered
- `GTOn` out 1, grant-timeout strobe, one-cycle low pulse
- `OWNER` out [$clog2(SLOTS+2)-1:0], 0 = CPU/none, 1..SLOTS = slot, SLOTS+1 = coprocessor

## Operation
- Reset (RESETn low at an edge): state IDLE, BRn=1, BG=all 1, CBGn=1, GTOn=1, OWNER=0, timeout counter 0, BGOLDn=1, RR pointer=SLOTS (slot 1 is next). Applies mid-operation; every grant drops at the next edge.
- BGOLDn registers BGn every cycle. A grant edge is BGn==0 && BGOLDn==1.
- IDLE: BRn=1. Any BR[i] low or CBRn low -> REQ.
- REQ: BRn=0. On a grant edge, pick a winner among current requesters -> GRANT, drive that grant low and load OWNER. If no requester remains at the grant edge -> IDLE with no grant. BGn already low on entry is ignored until it rises and falls again.
- Winner selection: CBRn always beats every slot. Slot order is set by the configuration mode.
- GRANT: the winner's grant is held low and the counter increments every cycle.
  - OWNn low -> OWNED. The grant goes high, OWNER is held.
  - The winner's request goes high while OWNn is high -> IDLE. The grant goes high, OWNER=0, no GTOn pulse.
  - Counter reaches GRANT_TIMEOUT-1 with OWNn high -> IDLE. The grant goes high, GTOn=0 for one cycle, OWNER=0.
  - OWNn low on the terminal count cycle takes precedence: go to OWNED, no GTOn pulse.
- OWNED: BRn=1, all grants high. New requests are queued; they are not forwarded. OWNn high -> IDLE, OWNER=0.
- At most one of BG/CBGn is low in any cycle.
- The counter width is $clog2(GRANT_TIMEOUT). It saturates and never wraps.

## Timing
- Request low sampled at edge k in IDLE -> BRn low after edge k+1.
- Grant edge sampled at edge m -> BG[i]/CBGn low and OWNER valid after edge m+1.
- OWNn low sampled at edge n in GRANT -> grant high after edge n+1.
- OWNn high sampled in OWNED at edge p -> IDLE after p+1. BRn re-asserts after p+2 if requests are pending.
- Timeout: a grant asserted after edge g is withdrawn after edge g+GRANT_TIMEOUT. GTOn is low for that one cycle only.

## Configuration
- `ROUND_ROBIN_EN` defined:
  - Slot priority rotates. The winner is the first requesting slot after the RR pointer, wrapping SLOTS->1.
  - The pointer updates to the winner on entering GRANT. It therefore also advances past a slot that timed out.
  - The coprocessor does not move the pointer.
- Undefined: fixed priority, BR[1] highest and BR[SLOTS] lowest. The pointer is absent.

## Test plan
- Reset mid-OWNED with BG[2] low and OWNER=2 -> after the next edge BRn=1, BG=5'b11111, CBGn=1, OWNER=0, GTOn=1.
- BR[3] low, BGn falls 3 cycles later, OWNn low 4 cycles after the grant, then high 10 cycles later:
  - BRn low 1 cycle after the request.
  - BG[3] low and OWNER=3 1 cycle after BGn falls.
  - BG[3] high 1 cycle after OWNn falls.
  - OWNER=0 1 cycle after OWNn rises.
- CBRn, BR[1] and BR[4] low together at the grant edge -> CBGn low and OWNER=6. Both modes give the same result.
- BR[1] and BR[4] held low across three arbitration rounds:
  - Fixed mode grants slots 1,1,1.
  - ROUND_ROBIN_EN grants slots 1,4,1.
- Grant BR[2] with OWNn held high:
  - Exactly 32 cycles after BG[2] falls, BG[2] returns high and GTOn pulses low once.
  - Same stimulus with OWNn low on cycle 32: goes to OWNED, no GTOn pulse.
- BR[5] deasserts during REQ before the grant edge -> no grant, IDLE, BRn high one cycle after the grant edge.
